// File: rtl/spi_target_mmio_rx_if.sv
// MMIO request/response bundle for spi_target_mmio_rx.
// Zero-wait bus: ready follows valid in the same cycle.
interface spi_target_mmio_rx_if #(
    parameter int ADDR_W = 12
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;

    modport master (
        output valid, we, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/spi_target_mmio_rx.sv
// SPI target receiver with DC-tagged RX FIFO, TX holding register and MMIO.
// Optional FRAME register at 0x010 under SPI_TARGET_FRAME_CNT_EN.
module spi_target_mmio_rx #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sclk,
    input  logic                spi_mosi,
    input  logic                spi_cs_n,
    input  logic                spi_dc,
    output logic                spi_miso,
    spi_target_mmio_rx_if.slave mmio,
    output logic                irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_n;

    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] dc_q;
    logic [1:0] cs_q;
    logic       cs_d;

    logic ctrl_pos, ctrl_en, ctrl_irq_en;
    logic [7:0] txdata;
    logic [7:0] tx_sh;
    logic [6:0] rx_sh;
    logic [2:0] bit_cnt;
    logic       ovf, abort;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic mosi_s, dc_s, cs_s;
    logic sample, shift_tx;
    logic load_tx, byte_done, abort_set, frame_end;
    logic push, pop;
    logic [7:0] rx_byte;

    logic wr_en, rd_en;
    logic sel_rx, sel_st, sel_ctrl, sel_tx, sel_frm;
    logic [31:0] status_w, ctrl_w, frame_w;
    logic unused_ok;

    // Synchronisers; cs resets to "active" so a low CS_N held through
    // reset release is not mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            mosi_q <= '0;
            dc_q   <= '0;
            cs_q   <= '0;
            cs_d   <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            mosi_q <= {mosi_q[0], spi_mosi};
            dc_q   <= {dc_q[0], spi_dc};
            cs_q   <= {cs_q[0], spi_cs_n};
            cs_d   <= cs_q[1];
        end
    end

    assign mosi_s    = mosi_q[1];
    assign dc_s      = dc_q[1];
    assign cs_s      = cs_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign sample  = ctrl_en & (ctrl_pos ? sclk_rise : sclk_fall);
    // No TX shift before the first sample of a byte: the MSB is
    // already presented by the load at the byte boundary.
    assign shift_tx = ctrl_en & (state == SHIFT) & (bit_cnt != 3'd0)
                    & (ctrl_pos ? sclk_fall : sclk_rise);
    assign rx_byte  = {rx_sh, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_tx   = 1'b0;
        byte_done = 1'b0;
        abort_set = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall && ctrl_en) begin
                    state_n = SHIFT;
                    load_tx = 1'b1;
                end
            end
            SHIFT: begin
                byte_done = sample & (bit_cnt == 3'd7);
                load_tx   = byte_done;
                if (cs_rise) begin
                    state_n   = IDLE;
                    frame_end = 1'b1;
                    abort_set = ~byte_done & ((bit_cnt != 3'd0) | sample);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= 8'hFF;
        end else begin
            if (!ctrl_en || state != SHIFT || cs_rise)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + 3'd1;
            if (state == SHIFT && sample)
                rx_sh <= rx_byte[6:0];
            if (load_tx)
                tx_sh <= txdata;
            else if (shift_tx)
                tx_sh <= {tx_sh[6:0], 1'b1};
        end
    end

    assign spi_miso = (ctrl_en && state == SHIFT) ? tx_sh[7] : 1'b1;

    assign wr_en    = mmio.valid & mmio.we & mmio.wstrb[0];
    assign rd_en    = mmio.valid & ~mmio.we;
    assign sel_rx   = mmio.addr == ADDR_W'('h000);
    assign sel_st   = mmio.addr == ADDR_W'('h004);
    assign sel_ctrl = mmio.addr == ADDR_W'('h008);
    assign sel_tx   = mmio.addr == ADDR_W'('h00C);
    assign sel_frm  = mmio.addr == ADDR_W'('h010);

    assign empty = count == '0;
    assign full  = count == CW'(FIFO_DEPTH);
    assign push  = byte_done & ~full;
    assign pop   = rd_en & sel_rx & ~empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {dc_s, rx_byte};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_pos    <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            txdata      <= 8'hFF;
            ovf         <= 1'b0;
            abort       <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (wr_en && sel_ctrl) begin
                ctrl_pos    <= mmio.wdata[0];
                ctrl_en     <= mmio.wdata[8];
                ctrl_irq_en <= mmio.wdata[9];
            end
            // A write in the reload cycle targets the following byte.
            if (wr_en && sel_tx)
                txdata <= mmio.wdata[7:0];
            else if (load_tx)
                txdata <= 8'hFF;
            ovf   <= (byte_done & full)
                   | (ovf & ~(wr_en & sel_st & mmio.wdata[2]));
            abort <= abort_set
                   | (abort & ~(wr_en & sel_st & mmio.wdata[3]));
            irq_o <= ctrl_irq_en & (~empty | ovf);
        end
    end

`ifdef SPI_TARGET_FRAME_CNT_EN
    logic [7:0] cur_bytes, cur_next, last_bytes, frames;

    assign cur_next = (byte_done && cur_bytes != 8'hFF)
                    ? cur_bytes + 8'd1 : cur_bytes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bytes  <= '0;
            last_bytes <= '0;
            frames     <= '0;
        end else begin
            if (state == IDLE)
                cur_bytes <= '0;
            else
                cur_bytes <= cur_next;
            if (wr_en && sel_frm) begin
                last_bytes <= '0;
                frames     <= '0;
            end else if (frame_end) begin
                last_bytes <= cur_next;
                frames     <= frames + 8'd1;
            end
        end
    end

    assign frame_w = {8'd0, frames, 8'd0, last_bytes};
`else
    assign frame_w = '0;
`endif

    assign status_w = {16'd0, 8'(count), 3'd0, ~cs_s, abort, ovf, full, empty};
    assign ctrl_w   = {22'd0, ctrl_irq_en, ctrl_en, 7'd0, ctrl_pos};

    assign mmio.ready = mmio.valid;

    always_comb begin
        mmio.rdata = '0;
        if (rd_en) begin
            unique case (1'b1)
                sel_rx:   if (!empty) mmio.rdata = {1'b1, 22'd0, mem[rd_ptr]};
                sel_st:   mmio.rdata = status_w;
                sel_ctrl: mmio.rdata = ctrl_w;
                sel_tx:   mmio.rdata = {24'd0, txdata};
                sel_frm:  mmio.rdata = frame_w;
                default:  mmio.rdata = '0;
            endcase
        end
    end

    assign unused_ok = ^{mmio.wdata[31:10], mmio.wstrb[3:1]};
endmodule

// File: tb/tb_spi_target_mmio_rx.sv
// Scoreboard bench for spi_target_mmio_rx: SPI master, queue model, MMIO monitor.
// Covers the FRAME register when SPI_TARGET_FRAME_CNT_EN is defined.
`timescale 1ns/1ps
module tb_spi_target_mmio_rx;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, dc = 1'b0;
    logic miso, irq;

    spi_target_mmio_rx_if #(.ADDR_W(ADDR_W)) bus ();

    spi_target_mmio_rx #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sclk (sclk),
        .spi_mosi (mosi),
        .spi_cs_n (cs_n),
        .spi_dc   (dc),
        .spi_miso (miso),
        .mmio     (bus.slave),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_a[$];

    // Reference model: plain queue plus sticky flags and TX holding byte.
    logic [8:0] mq[$];
    bit         m_ovf, m_abort;
    logic [7:0] m_tx;
    logic [31:0] m_ctrl;

    bit         mid_wr;
    logic [7:0] mid_val;

    function automatic void m_reset();
        mq.delete();
        m_ovf = 0;
        m_abort = 0;
        m_tx = 8'hFF;
        m_ctrl = '0;
    endfunction

    function automatic void m_push(input logic [8:0] v);
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back(v);
    endfunction

    function automatic logic [31:0] m_status();
        int n;
        n = mq.size();
        return {16'd0, 8'(n), 3'd0, ~cs_n, m_abort, m_ovf,
                n == DEPTH, n == 0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: every read handshake is matched against the scoreboard.
    initial begin
        logic [31:0] e;
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (bus.valid === 1'b1 && bus.we === 1'b0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected addr=%h got=%h",
                             bus.addr, bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    a = exp_a.pop_front();
                    if (bus.rdata !== e || bus.ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rd@%h got=%h ready=%b exp=%h",
                                 a, bus.rdata, bus.ready, e);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = 4'hF;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        if (a == 'h004) begin
            if (d[2]) m_ovf = 0;
            if (d[3]) m_abort = 0;
        end
        if (a == 'h008) m_ctrl = {22'd0, d[9], d[8], 7'd0, d[0]};
        if (a == 'h00C) m_tx = d[7:0];
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        exp_a.push_back(a);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = a;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic rd_rx();
        logic [31:0] e;
        logic [8:0] v;
        e = '0;
        if (mq.size() > 0) begin
            v = mq.pop_front();
            e = {1'b1, 22'd0, v};
        end
        rd('h000, e);
    endtask

    task automatic rd_st();
        rd('h004, m_status());
    endtask

    task automatic drain();
        int n;
        n = mq.size();
        for (int k = 0; k < n; k++) rd_rx();
    endtask

    // Master: each SCLK phase is 4 clk; MOSI changes on the shift edge.
    task automatic spi_bits(input logic [7:0] b, input int nb,
                            input bit pos, output logic [7:0] got);
        got = '0;
        for (int i = 7; i >= 8 - nb; i--) begin
            if (pos) begin
                mosi = b[i];
                repeat (4) @(negedge clk);
                sclk = 1'b1;
                got[i] = miso;
                repeat (4) @(negedge clk);
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                mosi = b[i];
                repeat (4) @(negedge clk);
                sclk = 1'b0;
                got[i] = miso;
                repeat (4) @(negedge clk);
            end
            if (mid_wr && i == 4) begin
                mid_wr = 0;
                wr('h00C, {24'd0, mid_val});
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] bs[$], input logic dcv,
                         input bit pos);
        logic [7:0] got, exp_tx;
        dc = dcv;
        repeat (2) @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        exp_tx = m_tx;
        m_tx = 8'hFF;
        foreach (bs[k]) begin
            spi_bits(bs[k], 8, pos, got);
            chk($sformatf("miso_byte%0d", k), {24'd0, got}, {24'd0, exp_tx});
            m_push({dcv, bs[k]});
            exp_tx = m_tx;
            m_tx = 8'hFF;
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] bs[$];
        logic [7:0] got;
        int n;
        bit pos;

        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bs[$];
        logic [7:0] got;
        int n;
        bit pos;

        bus.valid = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        mid_wr    = 0;
        mid_val   = '0;
        m_reset();

        repeat (3) @(negedge clk);
        chk("miso_reset", {31'd0, miso}, 32'd1);
        chk("irq_reset", {31'd0, irq}, 32'd0);
        chk("ready_reset", {31'd0, bus.ready}, 32'd0);
        chk("rdata_reset", bus.rdata, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_st();
        rd('h008, 32'd0);
        rd_rx();
        rd('h020, 32'd0);
        wr('h020, 32'hFFFF_FFFF);
        rd('h020, 32'd0);

        // Basic mode-0 burst of commands
        wr('h008, 32'h101);
        rd('h008, m_ctrl);
        bs = '{8'hAE, 8'hA1, 8'hC8, 8'hAF};
        frame(bs, 1'b0, 1'b1);
        rd_st();
        repeat (5) rd_rx();
        rd_st();

        // Data burst sampled on the falling edge
        wr('h008, 32'h100);
        bs = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        frame(bs, 1'b1, 1'b0);
        drain();
        rd_st();

        // TX holding register, then a write landing mid byte 0
        wr('h008, 32'h101);
        wr('h00C, 32'h5A);
        bs = '{8'($urandom), 8'($urandom)};
        frame(bs, 1'b1, 1'b1);
        mid_wr = 1;
        mid_val = 8'h96;
        bs = '{8'($urandom), 8'($urandom)};
        frame(bs, 1'b0, 1'b1);
        drain();

        // Overflow: 18 bytes into a 16-entry FIFO
        bs.delete();
        for (int k = 0; k < 18; k++) bs.push_back(8'($urandom));
        frame(bs, 1'b1, 1'b1);
        rd_st();
        drain();
        rd_st();
        wr('h004, 32'h4);
        rd_st();

        // Partial byte aborts, next byte clean
        dc = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        m_tx = 8'hFF;
        spi_bits(8'hC3, 5, 1'b1, got);
        cs_n = 1'b1;
        m_abort = 1;
        repeat (8) @(negedge clk);
        rd_st();
        bs = '{8'h3C};
        frame(bs, 1'b0, 1'b1);
        rd_st();
        drain();
        wr('h004, 32'h8);
        rd_st();

        // Interrupt on non-empty FIFO
        wr('h008, 32'h301);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        bs = '{8'($urandom)};
        frame(bs, 1'b1, 1'b1);
        chk("irq_pending", {31'd0, irq}, 32'd1);
        rd_rx();
        @(negedge clk);
        chk("irq_drained", {31'd0, irq}, 32'd0);

`ifdef SPI_TARGET_FRAME_CNT_EN
        wr('h008, 32'h101);
        wr('h010, 32'd0);
        bs.delete();
        for (int k = 0; k < 4; k++) bs.push_back(8'($urandom));
        frame(bs, 1'b1, 1'b1);
        drain();
        bs.delete();
        for (int k = 0; k < 8; k++) bs.push_back(8'($urandom));
        frame(bs, 1'b0, 1'b1);
        drain();
        rd('h010, 32'h0002_0008);
`else
        rd('h010, 32'd0);
`endif

        // Reset in the middle of a frame
        wr('h008, 32'h101);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'hF0, 3, 1'b1, got);
        bs = '{8'h12};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("miso_in_rst", {31'd0, miso}, 32'd1);
        rst_n = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);
        chk("miso_after_rst", {31'd0, miso}, 32'd1);
        rd_st();
        wr('h008, 32'h101);
        spi_bits(8'h55, 8, 1'b1, got);
        rd_st();
        chk("miso_idle_after_rst", {31'd0, miso}, 32'd1);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);

        // Randomized frames with interleaved reads
        for (int f = 0; f < 8; f++) begin
            pos = 1'($urandom);
            wr('h008, {22'd0, 2'b01, 7'd0, pos});
            if ($urandom_range(0, 1) == 1) wr('h00C, 32'($urandom_range(0, 255)));
            n = $urandom_range(1, 5);
            bs.delete();
            for (int k = 0; k < n; k++) bs.push_back(8'($urandom));
            frame(bs, 1'($urandom), pos);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) rd_rx();
            if ($urandom_range(0, 3) == 0) rd_st();
        end
        rd_st();
        drain();
        rd_rx();
        rd_st();

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_target_mmio_rx.md
Name: spi_target_mmio_rx

Overview:
SPI target (slave) peripheral that receives the byte stream driven by the SoC's SPI master peripheral: SCLK, MOSI, CS_N and DC.
- Each completed byte is tagged with its DC level and pushed into an RX FIFO that the CPU drains over MMIO.
- A single TX holding register is shifted out on MISO.
- Used as a loopback/peripheral target on the SoC bus and as a display-side bus monitor.

Parameters:
ADDR_W, 12, MMIO address width
FIFO_DEPTH, 16, RX FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
spi_sclk  in  1  SPI clock from master (asynchronous to clk)
spi_mosi  in  1  serial data from master
spi_cs_n  in  1  chip select, active-low
spi_dc  in  1  data/command flag (1=data, 0=command)
spi_miso  out  1  serial data to master
mmio_valid  in  1  bus request
mmio_ready  out  1  bus accept
mmio_we  in  1  1=write
mmio_addr  in  ADDR_W  byte address
mmio_wdata  in  32  write data
mmio_wstrb  in  4  byte enables (only byte 0 significant)
mmio_rdata  out  32  read data, valid when mmio_ready
irq_o  out  1  interrupt, level

Behaviour:
- Reset values: spi_miso=1, mmio_ready=0, mmio_rdata=0, irq_o=0, FIFO empty, CTRL=0, TXDATA=0xFF, OVF=0, bit counter=0.
- Synchronisation: sclk, mosi, cs_n and dc each pass through a 2-flop synchroniser, plus a third flop on sclk for edge detect.
  - Requirement: every SCLK high or low phase is >=3 clk cycles.
  - Latency from the SCLK edge to the internal sample is 3 clk cycles.
- CTRL (0x008): bit0 POS_EDGE, bit8 EN, bit9 IRQ_EN.
  - POS_EDGE=1: sample MOSI on rising SCLK; MISO updates on falling SCLK.
  - POS_EDGE=0: the opposite edges.
  - EN=0: edges are ignored, the bit counter is held at 0 and MISO is held at 1.
- Receive FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on synchronised CS_N falling while EN=1. On entry: bit counter=0, TX shifter loaded from TXDATA, TXDATA reset to 0xFF.
  - In SHIFT, each sample edge shifts MOSI into the shift register, MSB first, and increments the counter.
  - At count 8: push {dc_sync, byte} to the FIFO, counter=0, and reload the TX shifter from TXDATA (then TXDATA=0xFF).
  - SHIFT -> IDLE on CS_N rising. A partial byte (counter 1..7) is discarded and ABORT is set (sticky).
  - CS_N rising on the same cycle as the 8th sample edge: the byte is pushed, then the FSM goes to IDLE.
- FIFO full on push: byte dropped, OVF set (sticky), contents unchanged.
- Push and pop in the same cycle: both happen; count unchanged.
- MMIO: zero-wait, mmio_ready = mmio_valid combinationally; rdata decoded combinationally from addr.
  - Unmapped reads return 0; unmapped writes are ignored.
- 0x000 RXDATA (read)
  - Read data: bit31 VALID, bit8 DC, bits7:0 byte.
  - The handshake pops the FIFO if non-empty.
  - Empty read returns 0 and pops nothing.
- 0x004 STATUS
  - Read data: bit0 EMPTY, bit1 FULL, bit2 OVF, bit3 ABORT, bit4 CS_ACTIVE, bits15:8 count.
  - Write 1 to bit2/bit3 clears them. A set and a clear in the same cycle: set wins.
- 0x00C TXDATA: write loads byte 0 for the next byte boundary.
- irq_o = IRQ_EN & (~EMPTY | OVF), registered (1 clk latency).
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the FSM stays in IDLE until a fresh CS_N falling edge.

Optional Feature:
Macro SPI_TARGET_FRAME_CNT_EN.
- Defined: register 0x010 FRAME.
  - bits7:0 hold the byte count of the last completed frame, latched at CS_N rising and saturating at 255.
  - bits23:16 count frames, wrapping, and increment at CS_N rising.
  - Writes to 0x010 clear the register.
- Undefined: 0x010 reads 0, no counters are synthesised.

Test Plan:
- CTRL=0x101; CS low, DC=0; master sends AE,A1,C8,AF at SCLK=clk/8; CS high -> STATUS count=4; RXDATA reads 0x800000AE, 0x800000A1, 0x800000C8, 0x800000AF; a fifth read returns 0; EMPTY=1.
- DC=1 burst of 00..77 (8 bytes) with POS_EDGE=0 and master on the matching edge -> reads 0x80000100..0x80000177; STATUS bit3=0.
- TXDATA=0x5A before CS falls; 2-byte frame -> MISO byte0=0x5A, byte1=0xFF; TXDATA written during byte0 -> byte1 equals the written value.
- FIFO_DEPTH=16; 18 bytes sent without reads -> FULL=1, OVF=1, count=16, the first 16 bytes are intact; write 0x4 to STATUS -> OVF=0.
- CS high after 5 bits of 0xC3 -> nothing pushed, ABORT=1, next full byte 0x3C received correctly. Reset mid-frame -> FIFO empty and MISO=1 after release.
- IRQ_EN=1: first byte pushed -> irq_o rises 1 clk later; drain FIFO -> irq_o=0. With SPI_TARGET_FRAME_CNT_EN: after two frames of 4 and 8 bytes, FRAME=0x00020008.
